// File: rtl/aes_pkg.sv
// Shared AES types, FSM encoding and GF(2^8) helpers.
// Inverse multipliers exist only when MIX_COLUMNS_INV_EN is defined.
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [31:0]  col_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } mixcol_state_t;

  localparam logic [7:0] AES_POLY = 8'h1b;

  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul3(input logic [7:0] b);
    return gf_xtime(b) ^ b;
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  function automatic logic [7:0] gf_mul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = gf_xtime(gf_xtime(gf_xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul11(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = gf_xtime(b);
    x8 = gf_xtime(gf_xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul13(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = gf_xtime(gf_xtime(b));
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] gf_mul14(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = gf_xtime(b);
    x4 = gf_xtime(x2);
    x8 = gf_xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction
`endif

endpackage

// File: rtl/mix_column_word.sv
// One MixColumns column: 32-bit in, 32-bit out, purely combinational.
// inv_i port exists only when MIX_COLUMNS_INV_EN is defined.
module mix_column_word
  import aes_pkg::*;
(
  input  col_t col_i,
`ifdef MIX_COLUMNS_INV_EN
  input  logic inv_i,
`endif
  output col_t col_o
);

  logic [7:0] a0, a1, a2, a3;
  col_t       fwd;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  assign fwd = {
    gf_xtime(a0) ^ gf_mul3(a1) ^ a2 ^ a3,
    a0 ^ gf_xtime(a1) ^ gf_mul3(a2) ^ a3,
    a0 ^ a1 ^ gf_xtime(a2) ^ gf_mul3(a3),
    gf_mul3(a0) ^ a1 ^ a2 ^ gf_xtime(a3)
  };

`ifdef MIX_COLUMNS_INV_EN
  col_t inv;

  assign inv = {
    gf_mul14(a0) ^ gf_mul11(a1) ^ gf_mul13(a2) ^ gf_mul9(a3),
    gf_mul9(a0) ^ gf_mul14(a1) ^ gf_mul11(a2) ^ gf_mul13(a3),
    gf_mul13(a0) ^ gf_mul9(a1) ^ gf_mul14(a2) ^ gf_mul11(a3),
    gf_mul11(a0) ^ gf_mul13(a1) ^ gf_mul9(a2) ^ gf_mul14(a3)
  };

  assign col_o = inv_i ? inv : fwd;
`else
  assign col_o = fwd;
`endif

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns, COLS_PER_CYCLE columns per clock.
// MIX_COLUMNS_INV_EN adds i_inv to select the inverse transform.
module mix_columns_iter
  import aes_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   i_valid,
  output logic   o_ready,
  input  state_t i_data,
`ifdef MIX_COLUMNS_INV_EN
  input  logic   i_inv,
`endif
  output logic   o_valid,
  input  logic   i_ready,
  output state_t o_data,
  output logic   o_busy
);

  localparam int          N        = COLS_PER_CYCLE;
  localparam logic [1:0]  CNT_STEP = 2'(N);
  localparam logic [1:0]  CNT_LAST = 2'(4 - N);

  mixcol_state_t state_q, state_d;
  state_t        work_q, work_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          inv_q, inv_d;

  logic [1:0]    lane_idx [N];
  col_t          lane_in  [N];
  col_t          lane_out [N];

  for (genvar l = 0; l < N; l++) begin : g_lane
    assign lane_idx[l] = cnt_q + 2'(l);
    assign lane_in[l]  = work_q[127 - 32*int'(lane_idx[l]) -: 32];

    mix_column_word u_word (
      .col_i (lane_in[l]),
`ifdef MIX_COLUMNS_INV_EN
      .inv_i (inv_q),
`endif
      .col_o (lane_out[l])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      inv_q   <= inv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_valid)           state_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_LAST) state_d = ST_DONE;
      ST_DONE: if (i_ready)           state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Working register doubles as the result buffer; columns update in place.
  always_comb begin
    work_d = work_q;
    cnt_d  = cnt_q;
    inv_d  = inv_q;
    if (state_q == ST_IDLE && i_valid) begin
      work_d = i_data;
      cnt_d  = '0;
`ifdef MIX_COLUMNS_INV_EN
      inv_d  = i_inv;
`else
      inv_d  = 1'b0;
`endif
    end else if (state_q == ST_BUSY) begin
      for (int l = 0; l < N; l++) begin
        work_d[127 - 32*int'(lane_idx[l]) -: 32] = lane_out[l];
      end
      cnt_d = cnt_q + CNT_STEP;
    end
  end

  always_comb begin
    o_ready = (state_q == ST_IDLE) && !rst;
    o_valid = (state_q == ST_DONE);
    o_busy  = (state_q == ST_BUSY);
    o_data  = (state_q == ST_DONE) ? work_q : '0;
  end

endmodule

// File: doc/mix_columns_iter.md
# mix_columns_iter

Iterative forward AES MixColumns engine: the encrypt-direction counterpart of the combinational `inv_mix_columns` block, used by the round datapath of the encryption core. Accepts a 128-bit state through a valid/ready handshake and transforms COLS_PER_CYCLE 32-bit columns per clock, sharing one or more column multipliers instead of four. It presents the result through a held-valid output handshake toward the AddRoundKey stage.

## Interface
- COLS_PER_CYCLE, 1, columns transformed per clock; legal values 1, 2, 4.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream offers i_data.
- o_ready  output  1  block can accept; high only in IDLE.
- i_data  input  128  state; byte k = i_data[127-8k -: 8]; column c = bytes 4c..4c+3.
- o_valid  output  1  o_data holds a finished result.
- i_ready  input  1  downstream accepts o_data.
- o_data  output  128  transformed state, same byte layout as i_data.
- o_busy  output  1  high in BUSY.

## Operation
- Reset values: o_ready=0 in the reset cycle, then 1 (IDLE); o_valid=0, o_busy=0, o_data=0, column counter=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: o_ready=1. When i_valid=1, capture i_data into the working register, clear the counter, go to BUSY.
  - BUSY: each cycle replace columns cnt..cnt+COLS_PER_CYCLE-1 in place; cnt += COLS_PER_CYCLE. After column 3 is written, go to DONE.
  - DONE: o_valid=1, o_data = working register, held stable. When i_ready=1, go to IDLE.
- Column transform: for input column (a0,a1,a2,a3), r0=2a0^3a1^a2^a3, r1=a0^2a1^3a2^a3, r2=a0^a1^2a2^3a3, r3=3a0^a1^a2^2a3.
  - xtime(b) = {b[6:0],0} ^ (b[7] ? 8'h1b : 8'h00).
  - 3b = xtime(b)^b.
  - All arithmetic is 8-bit GF(2^8); no carries.
- Columns are processed in ascending order, column 0 first.
- i_valid is ignored outside IDLE. i_data is only sampled on the accept edge.
- i_ready is ignored outside DONE. No new accept happens in the DONE→IDLE cycle.
- rst in any state: next cycle IDLE, all outputs at reset values. A partial result is discarded and never presented.

## Timing
- Accept edge T0: rising edge with IDLE and i_valid=1.
- BUSY occupies edges T1..T(4/COLS_PER_CYCLE).
- o_valid rises after edge T(4/COLS_PER_CYCLE), i.e. 4, 2 or 1 cycles after the accept edge.
- Handshake edge with DONE and i_ready=1: o_valid falls and o_ready rises after that edge.
- Minimum initiation interval is 4/COLS_PER_CYCLE + 2 cycles (i_ready held high).
- If i_ready is already high when DONE is entered, o_valid is high for exactly one cycle.

## Configuration
- MIX_COLUMNS_INV_EN defined: adds input port i_inv (1 bit), sampled on the accept edge with i_data.
  - i_inv=1 selects the inverse transform: r0=14a0^11a1^13a2^9a3, with rows rotated like the forward matrix.
  - The block then serves both directions with identical timing.
- MIX_COLUMNS_INV_EN undefined: no i_inv port, forward transform only, no inverse multiplier logic synthesized.

## Structure
- Package aes_pkg holds:
  - typedef state_t (logic [127:0]) and col_t (logic [31:0]).
  - FSM enum mixcol_state_t.
  - Constant AES_POLY = 8'h1b.
  - Functions gf_xtime and gf_mul3; gf_mul9/11/13/14 under MIX_COLUMNS_INV_EN.
- Sub-module mix_column_word: combinational col_t → col_t, one per column handled per cycle. Has an inv input only when MIX_COLUMNS_INV_EN is defined.

## Test plan
- FIPS-197 vector, COLS_PER_CYCLE=1: i_data=db135345_f20a225c_01010101_c6c6c6c6 → o_data=8e4da1bc_9fdc589d_01010101_c6c6c6c6, o_valid high 4 cycles after accept.
- Second vector with i_ready held low 10 cycles: i_data=d4d4d4d5_2d26314c_00000000_ffffffff → o_data=d5d5d7d6_4d7ebdf8_00000000_ffffffff held stable, o_ready=0, until i_ready.
- rst asserted at the second BUSY cycle → next cycle IDLE, o_valid=0, o_data=0. A new vector afterwards completes correctly.
- i_valid toggled with new data during BUSY/DONE → ignored; output matches the originally accepted state.
- Repeat vector 1 with COLS_PER_CYCLE=2 and 4 → latency 2 and 1 cycles, identical o_data.
- With MIX_COLUMNS_INV_EN: i_inv=1 on 8e4da1bc_9fdc589d_01010101_c6c6c6c6 → db135345_f20a225c_01010101_c6c6c6c6.
